character_jump: RTL and testbench
=================================

Name: character_jump

Overview:
- Motion controller directly downstream of the game state machine.
- Consumes the single-cycle jump_left / jump_right commands and animates the character along a parabolic hop to the adjacent block column.
- Checks whether a block exists under the landing column. Returns character_landed to the state machine on success; on a miss, returns jump_fail and animates a fall.
- Drives the pixel position consumed by the character sprite renderer.

Parameters:
TICK_DIV, 650000, clk cycles per animation step (100 Hz at 65 MHz); bench uses 2
COLS, 8, number of block columns; legal column 0..COLS-1
COL_WIDTH, 128, pixels between adjacent column origins; must be divisible by 2*V0
X0, 0, x pixel of column 0
START_COL, 3, column after reset/respawn
Y_GROUND, 600, character y on a block
V0, 16, initial upward velocity in pixels/tick
FALL_DY, 8, pixels per tick while falling
Y_FLOOR, 768, fall terminates when ypos >= Y_FLOOR

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-low reset
jump_left  in  1  1-cycle request: hop one column left
jump_right  in  1  1-cycle request: hop one column right
respawn  in  1  1-cycle: return to START_COL on ground
block_map  in  COLS  bit c = 1 means a block exists in column c
xpos  out  11  character x pixel
ypos  out  11  character y pixel (0 = top)
column  out  $clog2(COLS)  current/target column index
facing  out  1  0 = right, 1 = left; set at jump start
busy  out  1  high in any state other than IDLE
character_landed  out  1  1-cycle pulse, successful landing
jump_fail  out  1  1-cycle pulse, landing column empty or off-grid

Behaviour:
- Reset (rst = 0 at a clk edge) is synchronous and active-low; it has priority over everything.
  - State = IDLE, column = START_COL, xpos = X0 + START_COL*COL_WIDTH, ypos = Y_GROUND.
  - facing = 0, busy = 0, character_landed = 0, jump_fail = 0.
  - Tick counter = 0.
- Tick generator: counter 0..TICK_DIV-1; tick = 1 for one cycle when counter = TICK_DIV-1. Counter clears on reset and on any accepted jump, so step k of a motion occurs exactly TICK_DIV*(k+1) cycles after acceptance.
- States: IDLE, JUMP, FALL, DOWN.
  - IDLE → JUMP when exactly one of jump_left / jump_right is high.
    - Latch dir, set facing, t = 0, vy = V0.
    - jump_left and jump_right both high at once: ignored, no change.
    - Requests outside IDLE: ignored, never queued.
  - JUMP: on each tick:
    - ypos := ypos - vy (signed), then vy := vy - 1.
    - For t < 2*V0: xpos += or -= COL_WIDTH/(2*V0), according to dir.
    - t increments. Ticks t = 0..2*V0 give 2*V0+1 steps; ypos returns exactly to Y_GROUND with apex Y_GROUND - V0*(V0+1)/2 (464 with defaults) after tick 15.
    - On the final tick t = 2*V0, compute target = column ± 1 and sample block_map in that same cycle.
    - Landing success (target within 0..COLS-1 and block_map[target] = 1): column := target, character_landed = 1 for the next cycle, → IDLE.
    - Landing failure (otherwise): jump_fail = 1 for the next cycle, → FALL. column := target, saturated to 0..COLS-1; xpos is still updated.
  - FALL: on each tick, ypos += FALL_DY. When the new ypos >= Y_FLOOR, clamp ypos = Y_FLOOR and → DOWN.
  - DOWN: hold position; only respawn exits.
- respawn in any state: next cycle restores the reset position values, state → IDLE, no pulse emitted.
- Pulses: character_landed and jump_fail are registered and never both high.
- Arithmetic: xpos and ypos internal math is 12-bit signed; outputs are the lower 11 bits. No wrap is reachable with legal parameters.
- block_map changes mid-jump have no effect except at the final tick sample.

Decomposition:
- Shared game_pkg:
  - Screen constants: 1024x768, Y_GROUND, Y_FLOOR.
  - Column geometry: COLS, COL_WIDTH, X0.
  - Key and state-code localparams used by the state machine.
- One sub-module: anim_tick, the TICK_DIV divider with a synchronous clear input and a tick output.

Test Plan:
1. Reset, then idle 10 cycles → column = 3, xpos = 384, ypos = 600, all pulses 0, busy = 0.
2. TICK_DIV = 2, block_map = 8'hFF, jump_right pulse → after 66 cycles: xpos = 512, ypos = 600, column = 4; apex ypos = 464 after tick 15; character_landed high exactly 1 cycle; facing = 0.
3. block_map = 8'hF7 (column 3 empty), from column 4 pulse jump_left → jump_fail pulse once, FALL: ypos rises by 8 per tick until clamped at 768, then DOWN; later jump_right is ignored.
4. Column 0 with block_map = 8'hFF, jump_left → jump_fail (off-grid), column stays 0, fall to 768.
5. jump_left and jump_right asserted in the same cycle, then jump_right during JUMP → first ignored; second ignored with no queued hop after landing.
6. rst = 0 asserted mid-JUMP (ypos = 500), and separately respawn in DOWN → next cycle: position = (384, 600), state IDLE, no character_landed or jump_fail pulse.

Source files
------------

// File: rtl/game_pkg.sv
// Shared game constants: screen geometry, block column layout and motion state codes.
package game_pkg;

    localparam int unsigned SCREEN_W  = 1024;
    localparam int unsigned SCREEN_H  = 768;
    localparam int unsigned Y_GROUND  = 600;
    localparam int unsigned Y_FLOOR   = 768;

    localparam int unsigned COLS      = 8;
    localparam int unsigned COL_WIDTH = 128;
    localparam int unsigned X0        = 0;
    localparam int unsigned START_COL = 3;

    localparam int unsigned V0        = 16;
    localparam int unsigned FALL_DY   = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        JUMP = 2'd1,
        FALL = 2'd2,
        DOWN = 2'd3
    } jump_state_e;

    typedef enum logic {
        DIR_RIGHT = 1'b0,
        DIR_LEFT  = 1'b1
    } dir_e;

endpackage

// File: rtl/anim_tick.sv
// Animation step divider: one-cycle tick every TICK_DIV clocks, restartable by clr.
module anim_tick #(
    parameter int unsigned TICK_DIV = 650000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [CW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk) begin
        if (!rst || clr || tick) begin
            count <= '0;
        end else begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/character_jump.sv
// Character motion controller: parabolic hop to an adjacent column, landing check,
// fall animation on a miss, and the pixel position for the sprite renderer.
module character_jump #(
    parameter int unsigned TICK_DIV  = 650000,
    parameter int unsigned COLS      = game_pkg::COLS,
    parameter int unsigned COL_WIDTH = game_pkg::COL_WIDTH,
    parameter int unsigned X0        = game_pkg::X0,
    parameter int unsigned START_COL = game_pkg::START_COL,
    parameter int unsigned Y_GROUND  = game_pkg::Y_GROUND,
    parameter int unsigned V0        = game_pkg::V0,
    parameter int unsigned FALL_DY   = game_pkg::FALL_DY,
    parameter int unsigned Y_FLOOR   = game_pkg::Y_FLOOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     jump_left,
    input  logic                     jump_right,
    input  logic                     respawn,
    input  logic [COLS-1:0]          block_map,
    output logic [10:0]              xpos,
    output logic [10:0]              ypos,
    output logic [$clog2(COLS)-1:0]  column,
    output logic                     facing,
    output logic                     busy,
    output logic                     character_landed,
    output logic                     jump_fail
);

    import game_pkg::*;

    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned TW = $clog2(2*V0 + 2);

    localparam logic [TW-1:0]      T_LAST    = TW'(2*V0);
    localparam logic [TW-1:0]      T_ONE     = TW'(1);
    localparam logic signed [11:0] DX        = 12'(COL_WIDTH / (2*V0));
    localparam logic signed [11:0] X_START   = 12'(X0 + START_COL*COL_WIDTH);
    localparam logic signed [11:0] Y_GND     = 12'(Y_GROUND);
    localparam logic signed [11:0] Y_BOT     = 12'(Y_FLOOR);
    localparam logic signed [11:0] DY_FALL   = 12'(FALL_DY);
    localparam logic signed [11:0] VY_INIT   = 12'(V0);
    localparam logic signed [11:0] VY_ONE    = 12'sd1;
    localparam logic [CW-1:0]      COL_START = CW'(START_COL);
    localparam logic [CW-1:0]      COL_MAX   = CW'(COLS - 1);
    localparam logic [CW:0]        COLS_W    = (CW+1)'(COLS);
    localparam logic [CW+1:0]      C_ONE     = (CW+2)'(1);

    jump_state_e        state, state_n;
    dir_e               dir_q, dir_n;
    logic [CW-1:0]      col_q, col_n;
    logic signed [11:0] x_q, x_n, y_q, y_n, vy_q, vy_n, y_fall;
    logic [TW-1:0]      t_q, t_n;
    logic               face_q, face_n, land_q, land_n, fail_q, fail_n;
    logic               tick, accept;
    logic [CW+1:0]      target;
    logic               off_grid, target_ok;
    logic [CW-1:0]      target_sat;

    anim_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_comb begin
        accept = (state == IDLE) && !respawn && (jump_left ^ jump_right);

        // target carries a sign bit at [CW+1] so a hop left from column 0 reads as off-grid
        target     = (dir_q == DIR_LEFT) ? {2'b00, col_q} - C_ONE : {2'b00, col_q} + C_ONE;
        off_grid   = target[CW+1] || (target[CW:0] >= COLS_W);
        target_ok  = !off_grid && block_map[target[CW-1:0]];
        target_sat = target[CW+1] ? '0 : (off_grid ? COL_MAX : target[CW-1:0]);
        y_fall     = y_q + DY_FALL;

        state_n = state;
        dir_n   = dir_q;
        col_n   = col_q;
        x_n     = x_q;
        y_n     = y_q;
        vy_n    = vy_q;
        t_n     = t_q;
        face_n  = face_q;
        land_n  = 1'b0;
        fail_n  = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n = JUMP;
                    dir_n   = jump_left ? DIR_LEFT : DIR_RIGHT;
                    face_n  = jump_left;
                    t_n     = '0;
                    vy_n    = VY_INIT;
                end
            end
            JUMP: begin
                if (tick) begin
                    y_n  = y_q - vy_q;
                    vy_n = vy_q - VY_ONE;
                    t_n  = t_q + T_ONE;
                    if (t_q < T_LAST) begin
                        x_n = (dir_q == DIR_LEFT) ? x_q - DX : x_q + DX;
                    end else if (target_ok) begin
                        col_n   = target[CW-1:0];
                        land_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        col_n   = target_sat;
                        fail_n  = 1'b1;
                        state_n = FALL;
                    end
                end
            end
            FALL: begin
                if (tick) begin
                    if (y_fall >= Y_BOT) begin
                        y_n     = Y_BOT;
                        state_n = DOWN;
                    end else begin
                        y_n = y_fall;
                    end
                end
            end
            default: ;
        endcase

        if (respawn) begin
            state_n = IDLE;
            col_n   = COL_START;
            x_n     = X_START;
            y_n     = Y_GND;
            land_n  = 1'b0;
            fail_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            dir_q  <= DIR_RIGHT;
            col_q  <= COL_START;
            x_q    <= X_START;
            y_q    <= Y_GND;
            vy_q   <= '0;
            t_q    <= '0;
            face_q <= 1'b0;
            land_q <= 1'b0;
            fail_q <= 1'b0;
        end else begin
            state  <= state_n;
            dir_q  <= dir_n;
            col_q  <= col_n;
            x_q    <= x_n;
            y_q    <= y_n;
            vy_q   <= vy_n;
            t_q    <= t_n;
            face_q <= face_n;
            land_q <= land_n;
            fail_q <= fail_n;
        end
    end

    assign xpos             = x_q[10:0];
    assign ypos             = y_q[10:0];
    assign column           = col_q;
    assign facing           = face_q;
    assign busy             = (state != IDLE);
    assign character_landed = land_q;
    assign jump_fail        = fail_q;

endmodule

// File: tb/tb_character_jump.sv
// Scoreboarded bench for character_jump: hops are predicted from column/pixel rules,
// landing and fail pulses are checked by an independent monitor.
module tb_character_jump;

    localparam int TB_TICK = 2;
    localparam int V0      = 16;
    localparam int COL_W   = 128;
    localparam int Y_G     = 600;
    localparam int Y_FL    = 768;
    localparam int FDY     = 8;
    localparam int START   = 3;
    localparam int NCOLS   = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        jump_left = 1'b0;
    logic        jump_right = 1'b0;
    logic        respawn = 1'b0;
    logic [7:0]  block_map = 8'hFF;
    logic [10:0] xpos, ypos;
    logic [2:0]  column;
    logic        facing, busy, character_landed, jump_fail;

    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit landed;
        int cyc;
        int col;
        int x;
        int y;
        bit face;
    } exp_t;

    exp_t sb[$];

    int m_col = START;
    int m_x   = START * COL_W;
    bit m_down = 1'b0;

    character_jump #(.TICK_DIV(TB_TICK)) dut (
        .clk              (clk),
        .rst              (rst),
        .jump_left        (jump_left),
        .jump_right       (jump_right),
        .respawn          (respawn),
        .block_map        (block_map),
        .xpos             (xpos),
        .ypos             (ypos),
        .column           (column),
        .facing           (facing),
        .busy             (busy),
        .character_landed (character_landed),
        .jump_fail        (jump_fail)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (character_landed || jump_fail) begin
            check("pulse_exclusive", character_landed & jump_fail, 0);
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_pulse: got landed=%0d fail=%0d, required no pulse (cycle %0d)",
                         character_landed, jump_fail, cyc);
            end else begin
                e = sb.pop_front();
                check("pulse_kind",  character_landed, e.landed);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_col",   column, e.col);
                check("pulse_x",     xpos, e.x);
                check("pulse_y",     ypos, e.y);
                check("pulse_face",  facing, e.face);
                check("pulse_busy",  busy, !e.landed);
            end
        end
    end

    task automatic model_home();
        m_col  = START;
        m_x    = START * COL_W;
        m_down = 1'b0;
    endtask

    task automatic check_rest(input string tag);
        check({tag, "_col"},  column, m_col);
        check({tag, "_x"},    xpos, m_x & 2047);
        check({tag, "_y"},    ypos, m_down ? Y_FL : Y_G);
        check({tag, "_busy"}, busy, m_down);
        check({tag, "_land"}, character_landed, 0);
        check({tag, "_fail"}, jump_fail, 0);
    endtask

    task automatic do_respawn();
        @(negedge clk);
        respawn = 1'b1;
        @(negedge clk);
        respawn = 1'b0;
        model_home();
        check_rest("respawn");
    endtask

    task automatic fall_and_recover(input int pulse_cyc);
        int n  = 0;
        int nf = (Y_FL - Y_G + FDY - 1) / FDY;
        while (ypos != Y_FL && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("fall_floor", ypos, Y_FL);
        check("fall_time",  cyc, pulse_cyc + TB_TICK * nf);
        jump_right = 1'b1;
        @(negedge clk);
        jump_right = 1'b0;
        repeat (80) @(negedge clk);
        check_rest("down_hold");
        do_respawn();
    endtask

    task automatic hop(input bit left, input bit poke);
        exp_t e;
        int n0, x0, tgt, apex_cyc, n;
        @(negedge clk);
        n0  = cyc;
        x0  = m_x;
        tgt = m_col + (left ? -1 : 1);
        m_x = m_x + (left ? -COL_W : COL_W);
        e.landed = (tgt >= 0) && (tgt < NCOLS) && (block_map[tgt] == 1'b1);
        m_col  = e.landed ? tgt : ((tgt < 0) ? 0 : ((tgt >= NCOLS) ? NCOLS - 1 : tgt));
        m_down = !e.landed;
        e.cyc  = n0 + 1 + TB_TICK * (2 * V0 + 1);
        e.col  = m_col;
        e.x    = m_x & 2047;
        e.y    = Y_G;
        e.face = left;
        sb.push_back(e);
        if (left) jump_left = 1'b1;
        else      jump_right = 1'b1;
        @(negedge clk);
        jump_left  = 1'b0;
        jump_right = 1'b0;
        apex_cyc = n0 + 1 + TB_TICK * V0;
        while (cyc < apex_cyc) @(negedge clk);
        check("apex_y",    ypos, Y_G - V0 * (V0 + 1) / 2);
        check("apex_x",    xpos, (x0 + (left ? -COL_W / 2 : COL_W / 2)) & 2047);
        check("apex_busy", busy, 1);
        if (poke) begin
            jump_right = 1'b1;
            @(negedge clk);
            jump_right = 1'b0;
        end
        n = 0;
        while (sb.size() != 0 && n < 150) begin
            @(negedge clk);
            n++;
        end
        check("pulse_arrived", sb.size(), 0);
        sb.delete();
        @(negedge clk);
        if (m_down) fall_and_recover(e.cyc);
        else        check_rest("land");
    endtask

    task automatic both_pressed();
        @(negedge clk);
        jump_left  = 1'b1;
        jump_right = 1'b1;
        @(negedge clk);
        jump_left  = 1'b0;
        jump_right = 1'b0;
        check("both_busy", busy, 0);
        repeat (70) @(negedge clk);
        check_rest("both_ignored");
    endtask

    task automatic midjump_reset();
        int n = 0;
        @(negedge clk);
        jump_right = 1'b1;
        @(negedge clk);
        jump_right = 1'b0;
        while (ypos != 500 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("midjump_y", ypos, 500);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_home();
        check_rest("midjump_rst");
        check("midjump_face", facing, 0);
        repeat (80) @(negedge clk);
        check_rest("after_rst");
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, required completion");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_home();
        repeat (10) @(negedge clk);
        check_rest("reset");
        check("reset_face", facing, 0);

        block_map = 8'hFF;
        hop(1'b0, 1'b1);
        check("hop_right_face", facing, 0);
        repeat (70) @(negedge clk);
        check_rest("no_queue");

        block_map = 8'hF7;
        hop(1'b1, 1'b0);

        block_map = 8'hFF;
        repeat (3) hop(1'b1, 1'b0);
        hop(1'b1, 1'b0);

        both_pressed();
        midjump_reset();
        do_respawn();

        for (int i = 0; i < 16; i++) begin
            block_map = 8'($urandom | $urandom);
            if ($urandom_range(0, 3) == 0) both_pressed();
            hop(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        repeat (5) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
